// File: rtl/pci_master_single_if.sv
// Command/response handshake between a requester and pci_master_single.
// The requester attaches to the master modport and the PCI master core to slave.
interface pci_master_single_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic        cmd_io;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;

  modport master (
    output cmd_valid, cmd_write, cmd_io, cmd_addr, cmd_wdata, cmd_be,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_status
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_io, cmd_addr, cmd_wdata, cmd_be,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_status
  );
endinterface

// File: rtl/pci_master_single.sv
// Single-data-phase PCI bus master: turns each accepted command into one PCI
// transaction and reports completion status (00 ok, 01 master abort, 10 target abort, 11 retry).
module pci_master_single #(
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic               PCI_CLK,
  input  logic               PCI_RSTn,
  output logic               PCI_REQn,
  input  logic               PCI_GNTn,
  inout  wire                PCI_FRAMEn,
  inout  wire                PCI_IRDYn,
  inout  wire  [31:0]        PCI_AD,
  inout  wire  [3:0]         PCI_CBE,
  inout  wire                PCI_PAR,
  input  logic               PCI_TRDYn,
  input  logic               PCI_DEVSELn,
  input  logic               PCI_STOPn,
  pci_master_single_if.slave cmd
);

  typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, TURN} state_t;

  state_t      state;
  logic        req_n;
  logic        frame_oe, frame_out;
  logic        irdy_oe, irdy_out;
  logic        ad_oe;
  logic [31:0] ad_out;
  logic        cbe_oe;
  logic [3:0]  cbe_out;
  logic        par_oe, par_out;
  logic        cmd_ready_q;
  logic        rsp_valid_q;
  logic [1:0]  rsp_status_q;
  logic [31:0] rsp_rdata_q;
  logic        lat_write, lat_io;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0]  lat_be;
  logic        devsel_seen;
  logic [2:0]  devsel_cnt;

  logic        devsel_any;
  logic        timeout_hit;
  logic        data_done;
  logic [1:0]  data_status;

  assign PCI_REQn   = req_n;
  assign PCI_FRAMEn = frame_oe ? frame_out : 1'bz;
  assign PCI_IRDYn  = irdy_oe  ? irdy_out  : 1'bz;
  assign PCI_AD     = ad_oe    ? ad_out    : 32'hzzzz_zzzz;
  assign PCI_CBE    = cbe_oe   ? cbe_out   : 4'hz;
  assign PCI_PAR    = par_oe   ? par_out   : 1'bz;

  assign cmd.cmd_ready  = cmd_ready_q;
  assign cmd.rsp_valid  = rsp_valid_q;
  assign cmd.rsp_status = rsp_status_q;
  assign cmd.rsp_rdata  = rsp_rdata_q;

  assign devsel_any  = devsel_seen | ~PCI_DEVSELn;
  assign timeout_hit = {29'd0, devsel_cnt} >= 32'(DEVSEL_TIMEOUT - 1);

  // Data-phase termination, highest priority first; data_done=0 keeps waiting.
  always_comb begin
    data_done   = 1'b1;
    data_status = 2'b00;
    if (!PCI_TRDYn)
      data_status = 2'b00;
    else if (!PCI_STOPn && !PCI_DEVSELn)
      data_status = 2'b11;
    else if (!PCI_STOPn && devsel_seen)
      data_status = 2'b10;
    else if (!devsel_any && timeout_hit)
      data_status = 2'b01;
    else
      data_done = 1'b0;
  end

  always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
    if (!PCI_RSTn) begin
      state        <= IDLE;
      req_n        <= 1'b1;
      frame_oe     <= 1'b0;
      frame_out    <= 1'b1;
      irdy_oe      <= 1'b0;
      irdy_out     <= 1'b1;
      ad_oe        <= 1'b0;
      ad_out       <= '0;
      cbe_oe       <= 1'b0;
      cbe_out      <= '1;
      par_oe       <= 1'b0;
      par_out      <= 1'b0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= 2'b00;
      rsp_rdata_q  <= '0;
      lat_write    <= 1'b0;
      lat_io       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_be       <= '0;
      devsel_seen  <= 1'b0;
      devsel_cnt   <= '0;
    end else begin
      // PAR trails whatever AD/CBE this block drove in the previous cycle.
      par_oe      <= ad_oe;
      par_out     <= ^{ad_out, cbe_out};
      rsp_valid_q <= 1'b0;

      case (state)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd.cmd_valid && cmd_ready_q) begin
            lat_write   <= cmd.cmd_write;
            lat_io      <= cmd.cmd_io;
            lat_addr    <= cmd.cmd_addr;
            lat_wdata   <= cmd.cmd_wdata;
            lat_be      <= cmd.cmd_be;
            req_n       <= 1'b0;
            cmd_ready_q <= 1'b0;
            state       <= REQ;
          end
        end

        REQ: begin
          if (!PCI_GNTn && PCI_FRAMEn && PCI_IRDYn) begin
            state     <= ADDR;
            req_n     <= 1'b1;
            frame_oe  <= 1'b1;
            frame_out <= 1'b0;
            irdy_oe   <= 1'b1;
            irdy_out  <= 1'b1;
            ad_oe     <= 1'b1;
            ad_out    <= lat_io ? lat_addr : {lat_addr[31:2], 2'b00};
            cbe_oe    <= 1'b1;
            cbe_out   <= {1'b0, ~lat_io, 1'b1, lat_write};
          end
        end

        ADDR: begin
          state       <= DATA;
          frame_out   <= 1'b1;
          irdy_out    <= 1'b0;
          ad_oe       <= lat_write;
          ad_out      <= lat_wdata;
          cbe_out     <= ~lat_be;
          devsel_seen <= 1'b0;
          devsel_cnt  <= '0;
        end

        DATA: begin
          if (data_done) begin
            state        <= TURN;
            irdy_out     <= 1'b1;
            ad_oe        <= 1'b0;
            cbe_oe       <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= data_status;
            rsp_rdata_q  <= (!lat_write && data_status == 2'b00) ? PCI_AD : 32'd0;
          end else begin
            devsel_seen <= devsel_any;
            if (devsel_cnt != 3'd7)
              devsel_cnt <= devsel_cnt + 3'd1;
          end
        end

        TURN: begin
          state       <= IDLE;
          frame_oe    <= 1'b0;
          irdy_oe     <= 1'b0;
          cmd_ready_q <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pci_master_single.sv
// Directed bench for pci_master_single: plays a simple PCI target/arbiter and
// compares bus phases and responses against hand-computed values.
module tb_pci_master_single;

  logic        PCI_CLK = 1'b0;
  logic        PCI_RSTn;
  logic        PCI_GNTn, PCI_TRDYn, PCI_DEVSELn, PCI_STOPn;
  wire         PCI_REQn;
  wire         PCI_FRAMEn, PCI_IRDYn, PCI_PAR;
  wire  [31:0] PCI_AD;
  wire  [3:0]  PCI_CBE;

  logic        om_oe, om_frame, om_irdy;
  logic        tgt_ad_oe;
  logic [31:0] tgt_ad;

  int n_checks  = 0;
  int n_errors  = 0;
  int rsp_count = 0;

  logic [31:0] obs_addr_ad, obs_data_ad, obs_rdata;
  logic [3:0]  obs_addr_cbe, obs_data_cbe;
  logic        obs_addr_req, obs_data_frame, obs_data_irdy, obs_data_par, obs_turn_par;
  logic [1:0]  obs_status;
  int          obs_wait, obs_cycles;

  pci_master_single_if cmd_bus ();

  pci_master_single #(.DEVSEL_TIMEOUT(5)) dut (
    .PCI_CLK     (PCI_CLK),
    .PCI_RSTn    (PCI_RSTn),
    .PCI_REQn    (PCI_REQn),
    .PCI_GNTn    (PCI_GNTn),
    .PCI_FRAMEn  (PCI_FRAMEn),
    .PCI_IRDYn   (PCI_IRDYn),
    .PCI_AD      (PCI_AD),
    .PCI_CBE     (PCI_CBE),
    .PCI_PAR     (PCI_PAR),
    .PCI_TRDYn   (PCI_TRDYn),
    .PCI_DEVSELn (PCI_DEVSELn),
    .PCI_STOPn   (PCI_STOPn),
    .cmd         (cmd_bus)
  );

  // Released lines float high through the pullups, so Z reads back as all ones.
  assign PCI_FRAMEn = om_oe ? om_frame : 1'bz;
  assign PCI_IRDYn  = om_oe ? om_irdy  : 1'bz;
  assign PCI_AD     = tgt_ad_oe ? tgt_ad : 32'hzzzz_zzzz;
  pullup (PCI_FRAMEn);
  pullup (PCI_IRDYn);
  pullup (PCI_AD);
  pullup (PCI_CBE);
  pullup (PCI_PAR);

  always #5 PCI_CLK = ~PCI_CLK;

  always @(posedge PCI_CLK) if (cmd_bus.rsp_valid) rsp_count++;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkReleased(input string tag);
    checkOutput({tag, "_req"},       32'(PCI_REQn),          32'd1);
    checkOutput({tag, "_frame"},     32'(PCI_FRAMEn),        32'd1);
    checkOutput({tag, "_irdy"},      32'(PCI_IRDYn),         32'd1);
    checkOutput({tag, "_ad"},        PCI_AD,                 32'hFFFF_FFFF);
    checkOutput({tag, "_cbe"},       32'(PCI_CBE),           32'hF);
    checkOutput({tag, "_par"},       32'(PCI_PAR),           32'd1);
    checkOutput({tag, "_rsp_valid"}, 32'(cmd_bus.rsp_valid), 32'd0);
  endtask

  task automatic applyStimulus(input logic wr, input logic io, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    int w = 0;
    @(negedge PCI_CLK);
    while (!cmd_bus.cmd_ready && w < 20) begin
      @(negedge PCI_CLK);
      w++;
    end
    checkOutput("cmd_ready", 32'(cmd_bus.cmd_ready), 32'd1);
    cmd_bus.cmd_write = wr;
    cmd_bus.cmd_io    = io;
    cmd_bus.cmd_addr  = addr;
    cmd_bus.cmd_wdata = wdata;
    cmd_bus.cmd_be    = be;
    cmd_bus.cmd_valid = 1'b1;
    @(negedge PCI_CLK);
    cmd_bus.cmd_valid = 1'b0;
  endtask

  // Target responds in DATA cycle numbers counted from 1; 0/99 mean never.
  task automatic playTarget(input int trdy_at, input int dev_from, input int dev_to,
                            input int stop_at, input logic rd, input logic [31:0] rdata);
    int  w = 0;
    int  k = 0;
    bit  got_rsp = 1'b0;
    while (!(PCI_FRAMEn === 1'b0 && !om_oe) && w < 40) begin
      @(negedge PCI_CLK);
      w++;
    end
    obs_wait = w;
    checkOutput("addr_phase_seen", 32'(PCI_FRAMEn), 32'd0);
    obs_addr_ad  = PCI_AD;
    obs_addr_cbe = PCI_CBE;
    obs_addr_req = PCI_REQn;
    while (!got_rsp && k < 12) begin
      @(negedge PCI_CLK);
      if (cmd_bus.rsp_valid) begin
        got_rsp      = 1'b1;
        obs_status   = cmd_bus.rsp_status;
        obs_rdata    = cmd_bus.rsp_rdata;
        obs_turn_par = PCI_PAR;
        PCI_TRDYn    = 1'b1;
        PCI_DEVSELn  = 1'b1;
        PCI_STOPn    = 1'b1;
        tgt_ad_oe    = 1'b0;
      end else begin
        k++;
        if (k == 1) begin
          obs_data_ad    = PCI_AD;
          obs_data_cbe   = PCI_CBE;
          obs_data_par   = PCI_PAR;
          obs_data_frame = PCI_FRAMEn;
          obs_data_irdy  = PCI_IRDYn;
        end
        PCI_TRDYn   = !(k == trdy_at);
        PCI_DEVSELn = !(k >= dev_from && k < dev_to);
        PCI_STOPn   = !(k == stop_at);
        tgt_ad      = rdata;
        tgt_ad_oe   = rd && (k == trdy_at);
      end
    end
    obs_cycles = k;
    checkOutput("rsp_seen", 32'(got_rsp), 32'd1);
    @(negedge PCI_CLK);
    checkReleased("after_turn");
    checkOutput("idle_cmd_ready", 32'(cmd_bus.cmd_ready), 32'd1);
  endtask

  initial begin
    int bad;
    int rc;
    int w;
    PCI_RSTn = 1'b0;
    PCI_GNTn = 1'b0;
    PCI_TRDYn = 1'b1;
    PCI_DEVSELn = 1'b1;
    PCI_STOPn = 1'b1;
    om_oe = 1'b0;
    om_frame = 1'b1;
    om_irdy = 1'b1;
    tgt_ad_oe = 1'b0;
    tgt_ad = '0;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_write = 1'b0;
    cmd_bus.cmd_io = 1'b0;
    cmd_bus.cmd_addr = '0;
    cmd_bus.cmd_wdata = '0;
    cmd_bus.cmd_be = '0;

    repeat (3) @(negedge PCI_CLK);
    checkReleased("reset");
    checkOutput("reset_cmd_ready", 32'(cmd_bus.cmd_ready), 32'd0);
    checkOutput("reset_status", 32'(cmd_bus.rsp_status), 32'd0);
    checkOutput("reset_rdata", cmd_bus.rsp_rdata, 32'd0);
    PCI_RSTn = 1'b1;

    $display("[TB] IO write");
    applyStimulus(1'b1, 1'b1, 32'h0000_0200, 32'hA5A5_0003, 4'hF);
    playTarget(1, 1, 99, 0, 1'b0, 32'h0);
    checkOutput("iow_addr_ad", obs_addr_ad, 32'h0000_0200);
    checkOutput("iow_addr_cbe", 32'(obs_addr_cbe), 32'h3);
    checkOutput("iow_addr_req", 32'(obs_addr_req), 32'd1);
    checkOutput("iow_data_ad", obs_data_ad, 32'hA5A5_0003);
    checkOutput("iow_data_cbe", 32'(obs_data_cbe), 32'h0);
    checkOutput("iow_data_frame", 32'(obs_data_frame), 32'd1);
    checkOutput("iow_data_irdy", 32'(obs_data_irdy), 32'd0);
    checkOutput("iow_addr_par", 32'(obs_data_par), 32'd1);
    checkOutput("iow_data_par", 32'(obs_turn_par), 32'd0);
    checkOutput("iow_cycles", 32'(obs_cycles), 32'd1);
    checkOutput("iow_status", 32'(obs_status), 32'd0);
    checkOutput("iow_rdata", obs_rdata, 32'd0);

    $display("[TB] IO read");
    applyStimulus(1'b0, 1'b1, 32'h0000_0204, 32'h0, 4'hF);
    playTarget(2, 1, 99, 0, 1'b1, 32'h1234_5678);
    checkOutput("ior_addr_ad", obs_addr_ad, 32'h0000_0204);
    checkOutput("ior_addr_cbe", 32'(obs_addr_cbe), 32'h2);
    checkOutput("ior_data_ad_released", obs_data_ad, 32'hFFFF_FFFF);
    checkOutput("ior_data_cbe", 32'(obs_data_cbe), 32'h0);
    checkOutput("ior_addr_par", 32'(obs_data_par), 32'd1);
    checkOutput("ior_turn_par_released", 32'(obs_turn_par), 32'd1);
    checkOutput("ior_cycles", 32'(obs_cycles), 32'd2);
    checkOutput("ior_status", 32'(obs_status), 32'd0);
    checkOutput("ior_rdata", obs_rdata, 32'h1234_5678);
    checkOutput("ior_rdata_hold", cmd_bus.rsp_rdata, 32'h1234_5678);

    $display("[TB] memory write");
    applyStimulus(1'b1, 1'b0, 32'h1000_0003, 32'hDEAD_BEEF, 4'b0101);
    playTarget(1, 1, 99, 0, 1'b0, 32'h0);
    checkOutput("mw_addr_ad", obs_addr_ad, 32'h1000_0000);
    checkOutput("mw_addr_cbe", 32'(obs_addr_cbe), 32'h7);
    checkOutput("mw_data_cbe", 32'(obs_data_cbe), 32'hA);
    checkOutput("mw_addr_par", 32'(obs_data_par), 32'd0);
    checkOutput("mw_data_par", 32'(obs_turn_par), 32'd0);
    checkOutput("mw_status", 32'(obs_status), 32'd0);

    $display("[TB] master abort");
    applyStimulus(1'b0, 1'b0, 32'h0000_3000, 32'h0, 4'b0011);
    playTarget(0, 99, 99, 0, 1'b0, 32'h0);
    checkOutput("ma_addr_cbe", 32'(obs_addr_cbe), 32'h6);
    checkOutput("ma_data_cbe", 32'(obs_data_cbe), 32'hC);
    checkOutput("ma_cycles", 32'(obs_cycles), 32'd5);
    checkOutput("ma_status", 32'(obs_status), 32'd1);
    checkOutput("ma_rdata", obs_rdata, 32'd0);

    $display("[TB] retry after read data");
    applyStimulus(1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
    playTarget(0, 1, 99, 2, 1'b0, 32'h0);
    checkOutput("retry_cycles", 32'(obs_cycles), 32'd2);
    checkOutput("retry_status", 32'(obs_status), 32'd3);
    checkOutput("retry_rdata", obs_rdata, 32'd0);

    $display("[TB] target abort");
    applyStimulus(1'b1, 1'b1, 32'h0000_0300, 32'h0000_0001, 4'b0001);
    playTarget(0, 1, 3, 3, 1'b0, 32'h0);
    checkOutput("tabort_data_cbe", 32'(obs_data_cbe), 32'hE);
    checkOutput("tabort_cycles", 32'(obs_cycles), 32'd3);
    checkOutput("tabort_status", 32'(obs_status), 32'd2);

    $display("[TB] arbitration wait and ignored command");
    PCI_GNTn = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0000_2000, 32'h1122_3344, 4'hF);
    checkOutput("arb_req_asserted", 32'(PCI_REQn), 32'd0);
    checkOutput("arb_cmd_ready_busy", 32'(cmd_bus.cmd_ready), 32'd0);
    cmd_bus.cmd_addr  = 32'h0999_0000;
    cmd_bus.cmd_write = 1'b0;
    cmd_bus.cmd_valid = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge PCI_CLK);
      if (PCI_FRAMEn !== 1'b1 || PCI_REQn !== 1'b0) bad++;
    end
    checkOutput("arb_no_grant_cycles", 32'(bad), 32'd0);
    cmd_bus.cmd_valid = 1'b0;
    PCI_GNTn = 1'b0;
    om_oe = 1'b1;
    om_frame = 1'b0;
    om_irdy = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge PCI_CLK);
      if (PCI_CBE !== 4'hF) bad++;
    end
    om_frame = 1'b1;
    @(negedge PCI_CLK);
    if (PCI_CBE !== 4'hF) bad++;
    checkOutput("arb_busy_bus_cycles", 32'(bad), 32'd0);
    om_oe = 1'b0;
    playTarget(1, 1, 99, 0, 1'b0, 32'h0);
    checkOutput("arb_addr_wait", 32'(obs_wait), 32'd1);
    checkOutput("arb_addr_ad", obs_addr_ad, 32'h0000_2000);
    checkOutput("arb_addr_cbe", 32'(obs_addr_cbe), 32'h7);
    checkOutput("arb_status", 32'(obs_status), 32'd0);

    $display("[TB] TRDY wins over STOP");
    applyStimulus(1'b0, 1'b0, 32'h0000_0050, 32'h0, 4'hF);
    playTarget(1, 1, 99, 1, 1'b1, 32'hCAFE_F00D);
    checkOutput("prio_status", 32'(obs_status), 32'd0);
    checkOutput("prio_rdata", obs_rdata, 32'hCAFE_F00D);

    $display("[TB] reset during data phase");
    applyStimulus(1'b1, 1'b1, 32'h0000_0600, 32'h0000_0055, 4'hF);
    w = 0;
    while (PCI_FRAMEn !== 1'b0 && w < 40) begin
      @(negedge PCI_CLK);
      w++;
    end
    @(negedge PCI_CLK);
    checkOutput("rst_data_par_driven", 32'(PCI_PAR), 32'd0);
    rc = rsp_count;
    PCI_RSTn = 1'b0;
    #1;
    checkReleased("mid_reset");
    checkOutput("mid_reset_cmd_ready", 32'(cmd_bus.cmd_ready), 32'd0);
    checkOutput("mid_reset_status", 32'(cmd_bus.rsp_status), 32'd0);
    checkOutput("mid_reset_rdata", cmd_bus.rsp_rdata, 32'd0);
    repeat (2) @(negedge PCI_CLK);
    PCI_RSTn = 1'b1;
    repeat (2) @(negedge PCI_CLK);
    checkOutput("rst_no_rsp", 32'(rsp_count - rc), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0208, 32'h0, 4'hF);
    playTarget(1, 1, 99, 0, 1'b1, 32'h0BAD_F00D);
    checkOutput("post_rst_addr_ad", obs_addr_ad, 32'h0000_0208);
    checkOutput("post_rst_status", 32'(obs_status), 32'd0);
    checkOutput("post_rst_rdata", obs_rdata, 32'h0BAD_F00D);
    checkOutput("post_rst_one_rsp", 32'(rsp_count - rc), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
